obs_sampler: RTL and testbench
==============================

// Module: obs_sampler
// PURPOSE
//  Parametrised POMDP observation sampler; successor to the 2-observation generator.
//  - Accepts one (state, action, random) request per handshake.
//  - Draws an observation o in [0, N_OBS) from the distribution observe[action][state][*].
//  - Uses a sequential cumulative scan: one table entry per cycle.
//  - Sits between the state-transition stage and the belief-update stage; out_valid is
//    the belief-update enable.
// PARAMETERS
//  N_STATE   2   number of hidden states
//  N_ACTION  3   number of actions
//  N_OBS     2   number of observations (>=2)
//  PROB_W    16  probability width, unsigned Q0.PROB_W (0x10000 == 1.0 is not representable)
// PORTS
//  clk          in   1                      clock; all logic on posedge
//  rst          in   1                      reset: synchronous, active-high
//  in_valid     in   1                      request valid
//  in_ready     out  1                      sampler can accept a request
//  cur_state    in   ST_W=$clog2(N_STATE)   current hidden state
//  action       in   AC_W=$clog2(N_ACTION)  chosen action
//  random       in   PROB_W                 uniform random draw
//  observe      in   PROB_W [N_ACTION][N_STATE][N_OBS]  per-observation probabilities
//  out_valid    out  1                      observation valid (belief-update enable)
//  out_ready    in   1                      consumer accepts the observation
//  observation  out  OB_W=$clog2(N_OBS)     sampled observation index
//  err          out  1                      request had out-of-range state or action
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//  - fsm=IDLE; in_ready=1; out_valid=0; observation=0; err=0; acc=0; idx=0.
//  - Any request in flight is discarded; no output is produced for it.
//  FSM states: IDLE, SCAN, DONE.
//  - in_ready = (fsm==IDLE). out_valid = (fsm==DONE).
//  IDLE:
//  - On in_valid&&in_ready: latch cur_state, action, random; acc=0; idx=0; go to SCAN.
//  - If latched action>=N_ACTION or state>=N_STATE: go to DONE instead, with
//    observation=0 and err=1.
//  SCAN (one step per cycle):
//  - sum = acc + observe[a][s][idx]; width PROB_W+$clog2(N_OBS)+1, no overflow possible.
//  - If random < sum, or idx==N_OBS-1: observation=idx, err=0, go to DONE.
//  - Otherwise: acc=sum, idx=idx+1.
//  - Last observation absorbs any residual mass, even if the table sums to < 1.0.
//  - A table summing to > 1.0 truncates the tail; this is not flagged.
//  - The compare is strict. A zero-probability entry is never selected unless it is the last.
//  Latency:
//  - Observation k: out_valid rises k+1 cycles after the accept edge.
//  - Range error: 1 cycle after the accept edge.
//  DONE:
//  - observation and err are held stable while out_valid=1 && out_ready=0.
//  - On out_ready: go to IDLE.
//  - No same-cycle re-accept: minimum request spacing is k+3 cycles.
//  - in_valid while busy is ignored; the requester must hold it until in_ready.
//  observe is a static configuration input. It must be stable from accept until DONE;
//  it is not latched.
//  Widths: each of ST_W, AC_W, OB_W has a minimum of 1 bit.
// STRUCTURE
//  - pomdp_pkg holds: prob_t (logic [PROB_W-1:0]); the width helper
//    clog2_min1(n) = (n>1)?$clog2(n):1; enum obs_fsm_e {IDLE, SCAN, DONE}.
//  - Single module, no sub-module. The scan step is one adder plus one comparator,
//    muxed by idx.
// TESTING (N_OBS=3, PROB_W=16, observe[1][0] = {0x4000, 0x4000, 0x8000})
//  - a=1, s=0, random=0x3FFF -> observation=0, err=0; out_valid 1 cycle after accept.
//  - random=0x4000 -> observation=1 after 2 cycles; random=0xFFFF -> observation=2 after
//    3 cycles (forced last).
//  - Entry 0 = 0x0000 and random=0x0000 -> observation=1. Entries {0,0,0} -> observation=2.
//  - out_ready=0 for 5 cycles in DONE -> out_valid, observation and err stable;
//    in_ready=0; a second in_valid is ignored.
//  - action=3 (N_ACTION=3) -> err=1, observation=0, 1 cycle after accept;
//    the next valid request gives err=0.
//  - rst=1 mid-SCAN -> next cycle fsm=IDLE, in_ready=1, out_valid=0; no stale output.

Source files
------------

// File: rtl/pomdp_pkg.sv
// Shared types and width helpers for the POMDP observation sampler.
package pomdp_pkg;

    localparam int PROB_W_DEF = 16;

    // Unsigned Q0.PROB_W probability at the default width
    typedef logic [PROB_W_DEF-1:0] prob_t;

    // Sampler control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } obs_fsm_e;

    // $clog2 clamped to at least one bit so single-entry ranges still get a port
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obs_sampler.sv
// POMDP observation sampler: draws an observation index from
// observe[action][state][*] by a sequential cumulative scan, one entry per cycle.
module obs_sampler
    import pomdp_pkg::*;
#(
    parameter int N_STATE  = 2,
    parameter int N_ACTION = 3,
    parameter int N_OBS    = 2,
    parameter int PROB_W   = 16,
    localparam int ST_W    = clog2_min1(N_STATE),
    localparam int AC_W    = clog2_min1(N_ACTION),
    localparam int OB_W    = clog2_min1(N_OBS)
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [ST_W-1:0]                                   cur_state,
    input  logic [AC_W-1:0]                                   action,
    input  logic [PROB_W-1:0]                                 random,
    input  logic [N_ACTION-1:0][N_STATE-1:0][N_OBS-1:0][PROB_W-1:0] observe,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [OB_W-1:0]                                   observation,
    output logic                                              err
);

    // Running sum never overflows: at most N_OBS entries each below 1.0
    localparam int SUM_W = PROB_W + $clog2(N_OBS) + 1;

    // Range limits one bit wider than the field so a power-of-two count still fits
    localparam logic [AC_W:0]   ACT_LIM  = N_ACTION[AC_W:0];
    localparam logic [ST_W:0]   ST_LIM   = N_STATE[ST_W:0];
    localparam logic [OB_W-1:0] LAST_IDX = OB_W'(N_OBS - 1);

    obs_fsm_e          fsm;
    logic [ST_W-1:0]   st_q;
    logic [AC_W-1:0]   act_q;
    logic [PROB_W-1:0] rnd_q;
    logic [SUM_W-1:0]  acc;
    logic [OB_W-1:0]   idx;

    logic [PROB_W-1:0] entry;
    logic [SUM_W-1:0]  sum;
    logic              hit;
    logic              range_bad;

    // Scan datapath: one table read, one add, one strict compare per cycle
    always_comb begin
        entry     = observe[act_q][st_q][idx];
        sum       = acc + SUM_W'(entry);
        hit       = (SUM_W'(rnd_q) < sum);
        range_bad = ({1'b0, act_q} >= ACT_LIM) || ({1'b0, st_q} >= ST_LIM);
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            observation <= '0;
            err         <= 1'b0;
            acc         <= '0;
            idx         <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        st_q     <= cur_state;
                        act_q    <= action;
                        rnd_q    <= random;
                        acc      <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        fsm      <= SCAN;
                    end
                end
                SCAN: begin
                    // Range check happens on the latched request, so an error
                    // costs the same single cycle as a hit on entry 0
                    if (range_bad) begin
                        observation <= '0;
                        err         <= 1'b1;
                        out_valid   <= 1'b1;
                        fsm         <= DONE;
                    end else if (hit || idx == LAST_IDX) begin
                        // Last entry absorbs any residual mass
                        observation <= idx;
                        err         <= 1'b0;
                        out_valid   <= 1'b1;
                        fsm         <= DONE;
                    end else begin
                        acc <= sum;
                        idx <= idx + OB_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm       <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    fsm       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obs_sampler.sv
// Scoreboard bench for obs_sampler: driver pushes model predictions, monitor
// pops and checks them whenever the sampler presents an observation.
module tb_obs_sampler;
    import pomdp_pkg::*;

    localparam int NS = 2;
    localparam int NA = 3;
    localparam int NO = 3;
    localparam int PW = 16;

    typedef struct {
        int obs;
        int err;
        int lat;
        int acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [0:0] cur_state = '0;
    logic [1:0] action = '0;
    logic [PW-1:0] random = '0;
    logic [NA-1:0][NS-1:0][NO-1:0][PW-1:0] observe = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [1:0] observation;
    logic err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit force_stall = 0;
    exp_t sb[$];

    obs_sampler #(.N_STATE(NS), .N_ACTION(NA), .N_OBS(NO), .PROB_W(PW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .cur_state(cur_state), .action(action), .random(random), .observe(observe),
        .out_valid(out_valid), .out_ready(out_ready), .observation(observation), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: walk the cumulative distribution, last entry takes what is left
    function automatic exp_t model(input int s, input int a, input int unsigned r);
        exp_t e;
        int unsigned cum;
        e.obs = 0; e.err = 0; e.lat = 1; e.acc_cyc = 0;
        if (a >= NA || s >= NS) begin
            e.err = 1;
            return e;
        end
        cum = 0;
        for (int o = 0; o < NO; o++) begin
            cum += observe[a][s][o];
            if (r < cum || o == NO - 1) begin
                e.obs = o;
                e.lat = o + 1;
                return e;
            end
        end
        return e;
    endfunction

    task automatic set_row(input int a, input int s, input int p0, input int p1, input int p2);
        observe[a][s][0] = p0[PW-1:0];
        observe[a][s][1] = p1[PW-1:0];
        observe[a][s][2] = p2[PW-1:0];
    endtask

    task automatic do_req(input int s, input int a, input int r);
        int guard;
        exp_t e;
        @(negedge clk);
        cur_state = s[0:0];
        action = a[1:0];
        random = r[PW-1:0];
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        e = model(s, a, r);
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            check("response_timeout", 0, 1);
            sb.delete();
        end
    endtask

    // Monitor: pop on the first cycle of each presentation, check hold while stalled
    initial begin : monitor
        bit held = 0;
        int h_obs = 0;
        int h_err = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 0;
            end else begin
                if (in_ready && out_valid) check("ready_valid_exclusive", 1, 0);
                if (out_valid) begin
                    if (held) begin
                        check("hold_obs", observation, h_obs);
                        check("hold_err", err, h_err);
                    end else if (sb.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("observation", observation, e.obs);
                        check("err", err, e.err);
                        check("latency", cyc - e.acc_cyc, e.lat);
                    end
                    h_obs = observation;
                    h_err = err;
                end else if (held) begin
                    check("valid_dropped_while_stalled", 0, 1);
                end
                out_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
                held = out_valid && !out_ready;
            end
        end
    end

    initial begin : driver
        int guard;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_observation", observation, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        // Directed table rows
        set_row(1, 0, 'h4000, 'h4000, 'h8000);
        do_req(0, 1, 'h3FFF);
        do_req(0, 1, 'h4000);
        do_req(0, 1, 'h7FFF);
        do_req(0, 1, 'h8000);
        do_req(0, 1, 'hFFFF);
        set_row(2, 1, 'h0000, 'h2000, 'h1000);
        do_req(1, 2, 'h0000);
        set_row(0, 1, 'h0000, 'h0000, 'h0000);
        do_req(1, 0, 'h0000);
        do_req(1, 0, 'hFFFF);
        do_req(0, 3, 'h1234);
        do_req(0, 1, 'h0000);

        // Stall in DONE with a competing request held high
        force_stall = 1;
        do_req(0, 1, 'h4000);
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1; action = 2'd0; random = '0;
            check("busy_in_ready", in_ready, 0);
            check("busy_out_valid", out_valid, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        force_stall = 0;

        // Randomized tables and requests
        for (int n = 0; n < 60; n++) begin
            int mode;
            for (int a = 0; a < NA; a++)
                for (int s = 0; s < NS; s++)
                    for (int o = 0; o < NO; o++) begin
                        mode = $urandom_range(0, 3);
                        observe[a][s][o] = (mode == 0) ? 16'h0000 :
                                           (mode == 1) ? PW'($urandom_range(0, 'h5555)) :
                                           PW'($urandom);
                    end
            do_req($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 'hFFFF));
        end

        // Reset while scanning: the in-flight request must vanish
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        set_row(1, 0, 'h4000, 'h4000, 'h8000);
        @(negedge clk);
        cur_state = 1'b0; action = 2'd1; random = 16'hFFFF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midscan_rst_in_ready", in_ready, 1);
        check("midscan_rst_out_valid", out_valid, 0);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("no_stale_output", out_valid, 0);
        end
        do_req(0, 1, 'h3FFF);

        guard = 0;
        while ((sb.size() != 0 || out_valid) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
